serial_byte_collector: RTL and testbench

//  Serial-to-parallel front end for the 8-bit D-flip-flop register stage.

---
 rtl/serial_byte_collector.sv | 107 ++++++++++
 tb/tb_serial_byte_collector.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_byte_collector.sv
// Serial-to-parallel collector: start strobe, WIDTH data bits, optional parity bit.
// The completed word is held on byte_out_o until the next frame completes.
module serial_byte_collector #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          LSB_FIRST  = 1'b1,
  parameter bit          PARITY_EN  = 1'b1,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             bit_in_i,
  input  logic             bit_valid_i,
  input  logic             abort_i,
  output logic [WIDTH-1:0] byte_out_o,
  output logic             byte_ready_o,
  output logic             parity_err_o,
  output logic             busy_o
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StShift, StParity, StDone} state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;
  logic [WIDTH-1:0] byte_out_q;
  logic             byte_ready_q;
  logic             parity_err_q;
  logic             exp_par;

  always_comb begin
    if (LSB_FIRST) begin
      shift_d = {bit_in_i, shift_q[WIDTH-1:1]};
    end else begin
      shift_d = {shift_q[WIDTH-2:0], bit_in_i};
    end
  end

  assign exp_par = PARITY_ODD ? ~^shift_q : ^shift_q;

  // Outputs are loaded on the edge that enters StDone so they are visible during StDone.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      shift_q      <= '0;
      byte_out_q   <= '0;
      byte_ready_q <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      byte_ready_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q <= StShift;
            cnt_q   <= '0;
            shift_q <= '0;
          end
        end
        StShift: begin
          if (abort_i) begin
            state_q <= StIdle;
          end else if (bit_valid_i) begin
            shift_q <= shift_d;
            if (cnt_q == CntW'(WIDTH - 1)) begin
              if (PARITY_EN) begin
                state_q <= StParity;
              end else begin
                state_q      <= StDone;
                byte_out_q   <= shift_d;
                byte_ready_q <= 1'b1;
                parity_err_q <= 1'b0;
              end
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
        end
        StParity: begin
          if (abort_i) begin
            state_q <= StIdle;
          end else if (bit_valid_i) begin
            state_q      <= StDone;
            byte_out_q   <= shift_q;
            byte_ready_q <= 1'b1;
            parity_err_q <= bit_in_i ^ exp_par;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign byte_out_o   = byte_out_q;
  assign byte_ready_o = byte_ready_q;
  assign parity_err_o = parity_err_q;
  assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_serial_byte_collector.sv
// Bench for serial_byte_collector: frame-level reference model checked every cycle,
// directed frames with literal expectations, then randomized traffic.
module tb_serial_byte_collector;

  localparam int unsigned W    = 8;
  localparam bit          LSB  = 1'b1;
  localparam bit          PEN  = 1'b1;
  localparam bit          PODD = 1'b0;

  logic         clock;
  logic         reset;
  logic         start;
  logic         bit_in;
  logic         bit_valid;
  logic         abort;
  logic [W-1:0] byte_out;
  logic         byte_ready;
  logic         parity_err;
  logic         busy;

  int checks = 0;
  int errors = 0;

  serial_byte_collector #(
    .WIDTH     (W),
    .LSB_FIRST (LSB),
    .PARITY_EN (PEN),
    .PARITY_ODD(PODD)
  ) dut (
    .clock_i     (clock),
    .reset_i     (reset),
    .start_i     (start),
    .bit_in_i    (bit_in),
    .bit_valid_i (bit_valid),
    .abort_i     (abort),
    .byte_out_o  (byte_out),
    .byte_ready_o(byte_ready),
    .parity_err_o(parity_err),
    .busy_o      (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a list of accepted bits; it completes when W+PEN bits arrived.
  typedef enum {MIdle, MColl, MDone} mphase_e;
  mphase_e      m_phase = MIdle;
  int           bits[$];
  logic [W-1:0] m_out;
  logic         m_rdy;
  logic         m_perr;
  logic         m_busy;
  bit           m_valid = 1'b0;
  bit           prev_rdy = 1'b0;
  int           dut_rdy_cnt = 0;

  always @(posedge clock) begin
    if (reset) begin
      m_valid = 1'b1;
      m_phase = MIdle;
      bits.delete();
      m_out  = '0;
      m_rdy  = 1'b0;
      m_perr = 1'b0;
    end else begin
      m_rdy = 1'b0;
      case (m_phase)
        MIdle: if (start) begin
          m_phase = MColl;
          bits.delete();
        end
        MColl: begin
          if (abort) begin
            m_phase = MIdle;
          end else if (bit_valid) begin
            bits.push_back(int'(bit_in));
            if (bits.size() == int'(W) + (PEN ? 1 : 0)) begin
              int ones;
              ones  = 0;
              m_out = '0;
              for (int i = 0; i < int'(W); i++) begin
                if (bits[i] != 0) m_out[LSB ? i : int'(W) - 1 - i] = 1'b1;
              end
              foreach (bits[i]) ones += bits[i];
              m_perr  = PEN && ((ones % 2) != (PODD ? 1 : 0));
              m_rdy   = 1'b1;
              m_phase = MDone;
            end
          end
        end
        default: m_phase = MIdle;
      endcase
    end
    m_busy = (m_phase != MIdle);
    #1;
    if (m_valid) begin
      check("byte_out", 32'(byte_out), 32'(m_out));
      check("byte_ready", 32'(byte_ready), 32'(m_rdy));
      check("parity_err", 32'(parity_err), 32'(m_perr));
      check("busy", 32'(busy), 32'(m_busy));
      if (prev_rdy) check("ready_not_back_to_back", 32'(byte_ready), 32'd0);
      prev_rdy = (byte_ready === 1'b1);
      if (byte_ready === 1'b1) dut_rdy_cnt++;
    end
  end

  task automatic drive(input logic r, input logic s, input logic v, input logic b, input logic a);
    @(negedge clock);
    reset     = r;
    start     = s;
    bit_valid = v;
    bit_in    = b;
    abort     = a;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
  endtask

  // Start cycle carries bit_valid=1 to show it is ignored; restart pulses start in gap cycles.
  task automatic send_frame(input logic [7:0] data, input logic par, input int gap,
                            input bit restart);
    drive(1'b0, 1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
    for (int i = 0; i < int'(W); i++) begin
      for (int g = 0; g < gap; g++) drive(1'b0, restart, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
      drive(1'b0, 1'b0, 1'b1, data[i], 1'b0);
    end
    if (PEN) begin
      for (int g = 0; g < gap; g++) drive(1'b0, restart, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
      drive(1'b0, 1'b0, 1'b1, par, 1'b0);
    end
  endtask

  task automatic expect_done(input logic [7:0] exp, input logic perr, input string tag);
    @(posedge clock);
    #2;
    check({tag, "_ready"}, 32'(byte_ready), 32'd1);
    check({tag, "_byte"}, 32'(byte_out), 32'(exp));
    check({tag, "_perr"}, 32'(parity_err), 32'(perr));
    check({tag, "_busy_done"}, 32'(busy), 32'd1);
    idle(1);
    @(posedge clock);
    #2;
    check({tag, "_ready_low"}, 32'(byte_ready), 32'd0);
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int cnt0;
    reset     = 1'b1;
    start     = 1'($urandom_range(0, 1));
    bit_valid = 1'($urandom_range(0, 1));
    bit_in    = 1'($urandom_range(0, 1));
    abort     = 1'($urandom_range(0, 1));
    @(posedge clock);
    drive(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    @(posedge clock);
    #2;
    check("reset_byte", 32'(byte_out), 32'h00);
    check("reset_ready", 32'(byte_ready), 32'd0);
    check("reset_perr", 32'(parity_err), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    idle(2);

    // Good frame, then same data with wrong parity.
    send_frame(8'hA5, 1'b0, 0, 1'b0);
    expect_done(8'hA5, 1'b0, "good");
    idle(2);
    cnt0 = dut_rdy_cnt;
    send_frame(8'hA5, 1'b1, 0, 1'b0);
    expect_done(8'hA5, 1'b1, "badpar");
    idle(2);
    check("badpar_one_pulse", 32'(dut_rdy_cnt - cnt0), 32'd1);

    // Abort after 4 bits; abort coincides with a valid bit.
    cnt0 = dut_rdy_cnt;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (4) drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(3);
    check("abort_no_ready", 32'(dut_rdy_cnt - cnt0), 32'd0);
    check("abort_byte_held", 32'(byte_out), 32'hA5);
    check("abort_busy", 32'(busy), 32'd0);
    send_frame(8'h81, 1'b0, 0, 1'b0);
    expect_done(8'h81, 1'b0, "after_abort");
    idle(2);

    // Gapped stream with start re-pulsed mid-frame.
    cnt0 = dut_rdy_cnt;
    send_frame(8'h3C, 1'b0, 2, 1'b1);
    expect_done(8'h3C, 1'b0, "gapped");
    idle(3);
    check("gapped_one_pulse", 32'(dut_rdy_cnt - cnt0), 32'd1);

    // Reset after 5 data bits.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (5) drive(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    @(posedge clock);
    #2;
    check("midreset_byte", 32'(byte_out), 32'h00);
    check("midreset_ready", 32'(byte_ready), 32'd0);
    check("midreset_perr", 32'(parity_err), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    idle(1);
    send_frame(8'h5A, 1'b0, 0, 1'b0);
    expect_done(8'h5A, 1'b0, "after_reset");
    idle(2);

    // Randomized traffic against the model.
    cnt0 = dut_rdy_cnt;
    for (int n = 0; n < 4000; n++) begin
      drive($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 39) == 0);
    end
    idle(4);
    checks++;
    if (dut_rdy_cnt - cnt0 < 20) begin
      errors++;
      $display("FAIL random_frames_completed: got %0d expected at least 20", dut_rdy_cnt - cnt0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
